ssd_scan_controller: RTL and testbench



---
 rtl/ssd_pkg.sv | 42 ++++
 rtl/ssd_driver.sv | 32 +++
 rtl/ssd_scan_controller.sv | 127 ++++++++++++
 tb/tb_ssd_scan_controller.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package ssd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_COMMIT  = 2'd2
    } state_t;

    localparam int DIGITS = 4;
    localparam int BCD_W  = 20;

    localparam logic [3:0] AN_D0 = 4'b1110;
    localparam logic [3:0] AN_D1 = 4'b1101;
    localparam logic [3:0] AN_D2 = 4'b1011;
    localparam logic [3:0] AN_D3 = 4'b0111;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
    function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = '0;
        for (int i = 0; i < BCD_W / 4; i++) begin
            r[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
        end
        return r;
    endfunction

    function automatic logic [3:0] an_of(input logic [1:0] sel);
        logic [3:0] a;
        case (sel)
            2'd0:    a = AN_D0;
            2'd1:    a = AN_D1;
            2'd2:    a = AN_D2;
            default: a = AN_D3;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/ssd_driver.sv
// Hex nibble to active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
import ssd_pkg::*;

module ssd_driver (
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (digit_i)
            4'h0: seg_o = 7'b1000000;
            4'h1: seg_o = 7'b1111001;
            4'h2: seg_o = 7'b0100100;
            4'h3: seg_o = 7'b0110000;
            4'h4: seg_o = 7'b0011001;
            4'h5: seg_o = 7'b0010010;
            4'h6: seg_o = 7'b0000010;
            4'h7: seg_o = 7'b1111000;
            4'h8: seg_o = 7'b0000000;
            4'h9: seg_o = 7'b0010000;
            4'hA: seg_o = 7'b0001000;
            4'hB: seg_o = 7'b0000011;
            4'hC: seg_o = 7'b1000110;
            4'hD: seg_o = 7'b0100001;
            4'hE: seg_o = 7'b0000110;
            4'hF: seg_o = 7'b0001110;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/ssd_scan_controller.sv
// Double-buffered 4-digit display: hex or double-dabble decimal conversion, then
// continuous anode/cathode scan. States: IDLE (accept) | CONVERT (16 dabble steps) | COMMIT (load disp).
import ssd_pkg::*;

module ssd_scan_controller #(
    parameter int REFRESH_DIV = 10000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] value_in,
    input  logic        value_valid,
    input  logic        decimal_mode,
    output logic        value_ready,
    output logic        busy,
    output logic        overflow,
    output logic [3:0]  an,
    output logic [6:0]  cathode
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    state_t             state_q, state_d;
    logic [15:0]        shift_q, shift_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [3:0]         iter_q, iter_d;
    logic               dec_q, dec_d;
    logic [15:0]        disp_q, disp_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         sel_q, sel_d;
    logic [3:0]         an_q;
    logic [6:0]         cathode_q;
    logic [BCD_W-1:0]   bcd_adj;
    logic [3:0]         nibble;
    logic [6:0]         seg_nxt;

    assign bcd_adj = bcd_add3(bcd_q);

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bcd_d   = bcd_q;
        iter_d  = iter_q;
        dec_d   = dec_q;
        disp_d  = disp_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (value_valid) begin
                    shift_d = value_in;
                    dec_d   = decimal_mode;
                    bcd_d   = '0;
                    iter_d  = 4'd0;
                    state_d = decimal_mode ? ST_CONVERT : ST_COMMIT;
                end
            end
            ST_CONVERT: begin
                bcd_d   = {bcd_adj[BCD_W-2:0], shift_q[15]};
                shift_d = {shift_q[14:0], 1'b0};
                iter_d  = iter_q + 4'd1;
                if (iter_q == 4'd15) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                // In hex mode shift_q was never shifted, so it still holds the captured value.
                disp_d  = dec_q ? bcd_q[15:0] : shift_q;
                ovf_d   = dec_q & (|bcd_q[BCD_W-1:16]);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            sel_d = sel_q + 2'd1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            sel_d = sel_q;
        end
        nibble = disp_q[{sel_d, 2'b00} +: 4];
    end

    ssd_driver u_driver (
        .digit_i (nibble),
        .seg_o   (seg_nxt)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bcd_q     <= '0;
            iter_q    <= '0;
            dec_q     <= 1'b0;
            disp_q    <= '0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
            sel_q     <= 2'd0;
            an_q      <= AN_D0;
            cathode_q <= SEG_ZERO;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bcd_q     <= bcd_d;
            iter_q    <= iter_d;
            dec_q     <= dec_d;
            disp_q    <= disp_d;
            ovf_q     <= ovf_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            // Anode and cathode share one edge so no digit ever shows its neighbour's segments.
            an_q      <= an_of(sel_d);
            cathode_q <= seg_nxt;
        end
    end

    assign value_ready = (state_q == ST_IDLE);
    assign busy        = ~value_ready;
    assign overflow    = ovf_q;
    assign an          = an_q;
    assign cathode     = cathode_q;

endmodule

// File: tb/tb_ssd_scan_controller.sv
// Randomized bench: cycle-level behavioural model of the display checked every cycle.
module tb_ssd_scan_controller;

    localparam int DIV = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] value_in = '0;
    logic        value_valid = 1'b0;
    logic        decimal_mode = 1'b0;
    logic        value_ready, busy, overflow;
    logic [3:0]  an;
    logic [6:0]  cathode;

    int total = 0;
    int bad   = 0;

    ssd_scan_controller #(.REFRESH_DIV(DIV)) dut (
        .clock        (clock),
        .reset        (reset),
        .value_in     (value_in),
        .value_valid  (value_valid),
        .decimal_mode (decimal_mode),
        .value_ready  (value_ready),
        .busy         (busy),
        .overflow     (overflow),
        .an           (an),
        .cathode      (cathode)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000; 4'h1: s = 7'b1111001; 4'h2: s = 7'b0100100; 4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001; 4'h5: s = 7'b0010010; 4'h6: s = 7'b0000010; 4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000; 4'h9: s = 7'b0010000; 4'hA: s = 7'b0001000; 4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110; 4'hD: s = 7'b0100001; 4'hE: s = 7'b0000110; default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Last four decimal digits of v, one per nibble.
    function automatic logic [15:0] dec_digits(input int v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    // Reference model: busy countdown, pending result, free-running scan position.
    bit          m_init = 0;
    int          m_cyc = 0;
    int          m_busy = 0;
    logic [15:0] m_disp = '0;
    logic [15:0] m_pend = '0;
    logic        m_ovf = 1'b0;
    logic        m_pend_ovf = 1'b0;
    logic [3:0]  m_an = 4'b1110;
    logic [6:0]  m_cath = 7'b1000000;

    initial begin
        logic [3:0]  an_tab [4];
        logic [15:0] prev;
        int          sel;
        an_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        forever begin
            @(posedge clock);
            if (reset) begin
                m_init = 1; m_cyc = 0; m_busy = 0; m_disp = '0; m_ovf = 1'b0;
                m_an = 4'b1110; m_cath = 7'b1000000;
            end else if (m_init) begin
                prev = m_disp;
                m_cyc++;
                sel = (m_cyc / DIV) % 4;
                m_an = an_tab[sel];
                m_cath = seg_of(4'((prev >> (4 * sel)) & 16'hF));
                if (m_busy == 0) begin
                    if (value_valid) begin
                        m_pend     = decimal_mode ? dec_digits(int'(value_in)) : value_in;
                        m_pend_ovf = decimal_mode && (int'(value_in) > 9999);
                        m_busy     = decimal_mode ? 17 : 1;
                    end
                end else begin
                    m_busy--;
                    if (m_busy == 0) begin
                        m_disp = m_pend;
                        m_ovf  = m_pend_ovf;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (m_init) begin
                chk("ready",    value_ready,  m_busy == 0);
                chk("busy",     busy,         m_busy != 0);
                chk("overflow", overflow,     m_ovf);
                chk("an",       an,           m_an);
                chk("cathode",  cathode,      m_cath);
                chk("disp",     dut.disp_q,   m_disp);
            end
        end
    end

    task automatic offer(input logic [15:0] v, input logic d);
        bit acc;
        acc = 0;
        for (int i = 0; i < 64 && !acc; i++) begin
            @(negedge clock);
            value_in = v; decimal_mode = d; value_valid = 1'b1;
            if (value_ready) begin
                @(posedge clock);
                #1;
                value_valid = 1'b0;
                acc = 1;
            end
        end
        value_valid = 1'b0;
        chk("accept", acc, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        idle(3);
        reset = 1'b0;
        chk("rst_an", an, 4'b1110);
        chk("rst_cathode", cathode, 7'b1000000);

        offer(16'h1A2F, 1'b0);
        idle(20);
        offer(16'd1234, 1'b1);
        idle(24);
        offer(16'd65535, 1'b1);
        offer(16'h0007, 1'b0);
        idle(20);
        offer(16'd999, 1'b1);
        offer(16'h0042, 1'b0);
        idle(20);

        offer(16'd4321, 1'b1);
        idle(9);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("midrst_ready", value_ready, 1);
        chk("midrst_disp", dut.disp_q, 0);
        chk("midrst_an", an, 4'b1110);
        chk("midrst_ovf", overflow, 0);
        idle(10);

        for (int t = 0; t < 40; t++) begin
            idle($urandom_range(0, 4));
            offer(16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
        end
        idle(30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
